// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo controller: serializer state
// encodings, handy ASCII constants and baud divisors for a 12 MHz clock.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int ASCII_0 = 48;
  localparam int ASCII_9 = 57;

  localparam int BAUD_DIV_9600   = 1250;
  localparam int BAUD_DIV_115200 = 104;

  // Total clock cycles one frame occupies on the line (start + data + stop).
  function automatic int frame_cycles(input int baud_div, input int data_bits);
    return (data_bits + 2) * baud_div;
  endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// Serial transmitter: takes one character on load_i while idle and sends a
// start bit, DATA_BITS data bits LSB first and one stop bit, each held for
// BAUD_DIV clock cycles.  busy_o is high for the whole frame.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  // State, bit timer, data index and shift register update once per clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and line level; the bit timer restarts at zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_o    = 1'b1;
    busy_o  = 1'b1;
    unique case (state_q)
      TX_IDLE: begin
        busy_o = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (load_i) begin
          shift_d = data_i;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_o = 1'b0;
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_o = shift_q[0];
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == BIT_LAST) begin
            idx_d   = '0;
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        tx_o = 1'b1;
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo controller: received characters (all of them, or only MATCH_CHAR in
// MODE 1) are queued in a small FIFO and replayed on the serial line.  A
// full FIFO drops new characters and latches overflow; match_led toggles on
// every received MATCH_CHAR regardless of MODE.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int                   BAUD_DIV   = BAUD_DIV_9600,
  parameter int                   DATA_BITS  = 8,
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   MODE       = 0,
  parameter logic [DATA_BITS-1:0] MATCH_CHAR = DATA_BITS'(ASCII_0)
) (
  input  logic                              hwclk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [DATA_BITS-1:0]              rx_data,
  output logic                              tx,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              match_led
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNTW-1:0] COUNT_FULL = CNTW'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 match_led_q, match_led_d;

  logic is_match, accept, fifo_full, fifo_empty, push, pop;
  logic ser_busy;

  // Accept/match decode and FIFO bookkeeping; a pop frees a slot for a push in the same cycle.
  always_comb begin
    is_match    = rx_valid && (rx_data == MATCH_CHAR);
    accept      = rx_valid && ((MODE == 0) || is_match);
    fifo_full   = (count_q == COUNT_FULL);
    fifo_empty  = (count_q == '0);
    pop         = !fifo_empty && !ser_busy;
    push        = accept && (!fifo_full || pop);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    match_led_d = match_led_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (accept && !push) begin
      overflow_d = 1'b1;
    end
    if (is_match) begin
      match_led_d = ~match_led_q;
    end
  end

  // Control registers; reset wins over any rx_valid in the same cycle.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      match_led_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      match_led_q <= match_led_d;
    end
  end

  // Character storage; contents need no reset because the pointers define validity.
  always_ff @(posedge hwclk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  uart_tx_ser #(
    .BAUD_DIV  (BAUD_DIV),
    .DATA_BITS (DATA_BITS)
  ) u_ser (
    .clk_i  (hwclk),
    .rst_i  (rst),
    .load_i (pop),
    .data_i (mem_q[rd_ptr_q]),
    .tx_o   (tx),
    .busy_o (ser_busy)
  );

  assign tx_busy    = ser_busy;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign match_led  = match_led_q;

endmodule
